// File: rtl/heq_pkg.sv
// Shared definitions for the histogram-equalisation sequencer:
// state encoding, default widths and the default phase timeout.
package heq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIST = 3'd1,
        ST_CDF  = 3'd2,
        ST_MAP  = 3'd3,
        ST_FIN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned CDF_W_DEF   = 20;
    localparam int unsigned TMO_W_DEF   = 24;
    localparam logic [23:0] TMO_MAX_DEF = 24'hFFFFFF;

    // True for the three engine-owning phases.
    function automatic logic is_phase(input state_t s);
        logic r;
        case (s)
            ST_HIST, ST_CDF, ST_MAP: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/heq_phase_timer.sv
// Per-phase cycle counter. Cleared whenever the sequencer is outside a phase
// or is leaving the current one, so every phase starts counting from zero.
// timeout is raised during the TMO_MAX-th cycle spent in a phase.
module heq_phase_timer #(
    parameter int unsigned      TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [TMO_W-1:0] cnt_r;
    logic [TMO_W-1:0] last_s;

    // Index of the last cycle allowed in a phase (cycles counted from zero).
    assign last_s = TMO_MAX - {{(TMO_W-1){1'b0}}, 1'b1};

    // Phase cycle counter: clear has priority over counting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TMO_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout = enable && (cnt_r == last_s);

endmodule

// File: rtl/heq_phase_sequencer.sv
// Top-level sequencer for histogram equalisation: runs the histogram,
// CDF and remap engines in turn, owns the shared scratchpad read port and
// the output write-enable, latches the CDF minimum and reports status.
module heq_phase_sequencer
    import heq_pkg::*;
#(
    parameter int unsigned      ADDR_W  = ADDR_W_DEF,
    parameter int unsigned      CDF_W   = CDF_W_DEF,
    parameter int unsigned      TMO_W   = TMO_W_DEF,
    parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_MAX_DEF)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              hist_start,
    input  logic              hist_done,
    output logic              cdf_start,
    input  logic              cdf_done,
    input  logic [CDF_W-1:0]  cdf_min_in,
    output logic              map_start,
    input  logic              map_done,
    output logic [CDF_W-1:0]  cdf_min,
    input  logic [ADDR_W-1:0] hist_sp_addr,
    input  logic [ADDR_W-1:0] cdf_sp_addr,
    input  logic [ADDR_W-1:0] map_sp_addr,
    output logic [ADDR_W-1:0] sp_addr,
    input  logic              cdf_we,
    input  logic              map_we,
    output logic              out_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        phase,
    output logic [31:0]       cycle_count
);

    state_t             state_r;
    logic               first_r;
    logic               hist_start_r;
    logic               cdf_start_r;
    logic               map_start_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic [CDF_W-1:0]   cdf_min_r;
    logic [31:0]        cycle_count_r;

    logic               in_phase_s;
    logic               phase_done_s;
    logic               accept_done_s;
    logic               leave_s;
    logic               count_on_s;
    logic               tmo_s;
    logic               timer_clear_s;
    logic [ADDR_W-1:0]  sp_addr_s;
    logic               out_we_s;

    // Select the done of the engine that owns the current phase; the first
    // cycle of a phase (the launch cycle) never accepts a done.
    always_comb begin
        in_phase_s   = is_phase(state_r);
        phase_done_s = 1'b0;
        case (state_r)
            ST_HIST: phase_done_s = hist_done;
            ST_CDF:  phase_done_s = cdf_done;
            ST_MAP:  phase_done_s = map_done;
            default: phase_done_s = 1'b0;
        endcase
        accept_done_s = in_phase_s && !first_r && phase_done_s;
        leave_s       = in_phase_s && (abort || accept_done_s || tmo_s);
        timer_clear_s = !in_phase_s || leave_s;
        count_on_s    = in_phase_s || (state_r == ST_FIN);
    end

    heq_phase_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear_s),
        .enable  (in_phase_s),
        .timeout (tmo_s)
    );

    // Run-control FSM with registered launch pulses, status and CDF latch.
    // Priority inside a phase: abort, then accepted done, then timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            first_r       <= 1'b0;
            hist_start_r  <= 1'b0;
            cdf_start_r   <= 1'b0;
            map_start_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            cdf_min_r     <= {CDF_W{1'b0}};
            cycle_count_r <= 32'd0;
        end else begin
            hist_start_r <= 1'b0;
            cdf_start_r  <= 1'b0;
            map_start_r  <= 1'b0;
            done_r       <= 1'b0;
            first_r      <= 1'b0;
            if (count_on_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
                cycle_count_r <= cycle_count_r + 32'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_HIST;
                        hist_start_r  <= 1'b1;
                        first_r       <= 1'b1;
                        busy_r        <= 1'b1;
                        error_r       <= 1'b0;
                        cycle_count_r <= 32'd0;
                    end
                end
                ST_HIST, ST_CDF, ST_MAP: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (accept_done_s) begin
                        case (state_r)
                            ST_HIST: begin
                                state_r     <= ST_CDF;
                                cdf_start_r <= 1'b1;
                                first_r     <= 1'b1;
                            end
                            ST_CDF: begin
                                state_r     <= ST_MAP;
                                map_start_r <= 1'b1;
                                first_r     <= 1'b1;
                                cdf_min_r   <= cdf_min_in;
                            end
                            default: begin
                                state_r <= ST_FIN;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        endcase
                    end else if (tmo_s) begin
                        state_r <= ST_ERR;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                    end
                end
                ST_FIN, ST_ERR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Grant the scratchpad address and output write-enable to the phase owner.
    always_comb begin
        sp_addr_s = {ADDR_W{1'b0}};
        out_we_s  = 1'b0;
        case (state_r)
            ST_HIST: sp_addr_s = hist_sp_addr;
            ST_CDF: begin
                sp_addr_s = cdf_sp_addr;
                out_we_s  = cdf_we;
            end
            ST_MAP: begin
                sp_addr_s = map_sp_addr;
                out_we_s  = map_we;
            end
            default: begin
                sp_addr_s = {ADDR_W{1'b0}};
                out_we_s  = 1'b0;
            end
        endcase
    end

    assign hist_start  = hist_start_r;
    assign cdf_start   = cdf_start_r;
    assign map_start   = map_start_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign cdf_min     = cdf_min_r;
    assign cycle_count = cycle_count_r;
    assign phase       = state_r;
    assign sp_addr     = sp_addr_s;
    assign out_we      = out_we_s;

endmodule

// File: tb/tb_heq_phase_sequencer.sv
// Bench for heq_phase_sequencer: a phase-level behavioural model checked
// against the DUT on every falling edge, plus hand-computed checkpoints.
module tb_heq_phase_sequencer;

    localparam int TMO = 16;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        start, abort, hist_done, cdf_done, map_done, cdf_we, map_we;
    logic [19:0] cdf_min_in;
    logic [15:0] hist_sp_addr, cdf_sp_addr, map_sp_addr;
    logic        hist_start, cdf_start, map_start, out_we, busy, done, error;
    logic [19:0] cdf_min;
    logic [15:0] sp_addr;
    logic [2:0]  phase;
    logic [31:0] cycle_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_hs = 0, n_cs = 0, n_ms = 0, n_dn = 0;

    // Model state: phase number, cycles already spent in it, run counters.
    int          m_ph  = 0;
    int          m_k   = 0;
    longint      m_cnt = 0;
    logic        m_err = 1'b0;
    logic [19:0] m_min = 20'h0;

    heq_phase_sequencer #(
        .ADDR_W (16), .CDF_W (20), .TMO_W (24), .TMO_MAX (24'd16)
    ) dut (
        .clock (clock), .reset_n (reset_n), .start (start), .abort (abort),
        .hist_start (hist_start), .hist_done (hist_done),
        .cdf_start (cdf_start), .cdf_done (cdf_done), .cdf_min_in (cdf_min_in),
        .map_start (map_start), .map_done (map_done), .cdf_min (cdf_min),
        .hist_sp_addr (hist_sp_addr), .cdf_sp_addr (cdf_sp_addr),
        .map_sp_addr (map_sp_addr), .sp_addr (sp_addr),
        .cdf_we (cdf_we), .map_we (map_we), .out_we (out_we),
        .busy (busy), .done (done), .error (error),
        .phase (phase), .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Behavioural model: advances one clock edge at a time.
    initial forever begin
        logic d;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_ph = 0; m_k = 0; m_cnt = 0; m_err = 1'b0; m_min = 20'h0;
        end else begin
            if (m_ph >= 1 && m_ph <= 4 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_ph == 0) begin
                if (start) begin m_ph = 1; m_k = 0; m_err = 1'b0; m_cnt = 0; end
            end else if (m_ph <= 3) begin
                d = (m_ph == 1) ? hist_done : (m_ph == 2) ? cdf_done : map_done;
                if (abort) m_ph = 0;
                else if (d && m_k > 0) begin
                    if (m_ph == 2) m_min = cdf_min_in;
                    m_ph = m_ph + 1;
                    m_k = 0;
                end else if (m_k + 1 == TMO) begin
                    m_ph = 5; m_err = 1'b1;
                end else m_k++;
            end else m_ph = 0;
        end
    end

    // Compare process: every falling edge, DUT vs model; also counts pulses.
    initial forever begin
        logic [15:0] e_sp;
        logic        e_we;
        @(negedge clock);
        e_sp = (m_ph == 1) ? hist_sp_addr : (m_ph == 2) ? cdf_sp_addr :
               (m_ph == 3) ? map_sp_addr : 16'h0;
        e_we = (m_ph == 2) ? cdf_we : (m_ph == 3) ? map_we : 1'b0;
        chk("phase", {29'd0, phase}, 32'(m_ph));
        chk("busy", {31'd0, busy}, {31'd0, (m_ph >= 1 && m_ph <= 3)});
        chk("done", {31'd0, done}, {31'd0, (m_ph == 4)});
        chk("error", {31'd0, error}, {31'd0, m_err});
        chk("hist_start", {31'd0, hist_start}, {31'd0, (m_ph == 1 && m_k == 0)});
        chk("cdf_start", {31'd0, cdf_start}, {31'd0, (m_ph == 2 && m_k == 0)});
        chk("map_start", {31'd0, map_start}, {31'd0, (m_ph == 3 && m_k == 0)});
        chk("cdf_min", {12'd0, cdf_min}, {12'd0, m_min});
        chk("cycle_count", cycle_count, m_cnt[31:0]);
        chk("sp_addr", {16'd0, sp_addr}, {16'd0, e_sp});
        chk("out_we", {31'd0, out_we}, {31'd0, e_we});
        if (hist_start === 1'b1) n_hs++;
        if (cdf_start === 1'b1) n_cs++;
        if (map_start === 1'b1) n_ms++;
        if (done === 1'b1) n_dn++;
    end

    initial begin
        start = 1'b0; abort = 1'b0; hist_done = 1'b0; cdf_done = 1'b0; map_done = 1'b0;
        cdf_we = 1'b0; map_we = 1'b0; cdf_min_in = 20'h0;
        hist_sp_addr = 16'h0; cdf_sp_addr = 16'h0; map_sp_addr = 16'h0;
        #1 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_cdf_min", {12'd0, cdf_min}, 32'd0);
        chk("rst_sp_addr", {16'd0, sp_addr}, 32'd0);

        // Nominal run with ownership checks on the resource mux.
        hist_sp_addr = 16'h0011; cdf_sp_addr = 16'h0022; map_sp_addr = 16'h0033;
        map_we = 1'b1; cdf_we = 1'b0;
        n_hs = 0; n_cs = 0; n_ms = 0; n_dn = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("nom_hist_phase", {29'd0, phase}, 32'd1);
        chk("nom_hist_start", {31'd0, hist_start}, 32'd1);
        chk("nom_hist_sp", {16'd0, sp_addr}, 32'h0011);
        tick(10); hist_done = 1'b1; tick(); hist_done = 1'b0;
        chk("nom_cdf_phase", {29'd0, phase}, 32'd2);
        chk("mux_cdf_sp", {16'd0, sp_addr}, 32'h0022);
        chk("mux_cdf_we_blocked", {31'd0, out_we}, 32'd0);
        cdf_min_in = 20'h00123;
        tick(5); cdf_done = 1'b1; tick(); cdf_done = 1'b0; cdf_min_in = 20'h0FFFF;
        chk("nom_map_phase", {29'd0, phase}, 32'd3);
        chk("mux_map_we", {31'd0, out_we}, 32'd1);
        chk("nom_cdf_min", {12'd0, cdf_min}, 32'h00123);
        tick(8); map_done = 1'b1; tick(); map_done = 1'b0;
        chk("nom_fin_phase", {29'd0, phase}, 32'd4);
        chk("nom_fin_done", {31'd0, done}, 32'd1);
        chk("nom_fin_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; tick();               // start during FIN is ignored
        chk("fin_start_ignored", {29'd0, phase}, 32'd0);
        chk("nom_cycle_count", cycle_count, 32'd27);
        chk("nom_cdf_min_held", {12'd0, cdf_min}, 32'h00123);
        chk("nom_pulses", {n_hs[7:0], n_cs[7:0], n_ms[7:0], n_dn[7:0]}, 32'h01010101);

        // Start right after FIN is accepted; early hist_done ignored.
        tick(); start = 1'b0; hist_done = 1'b1;
        chk("post_fin_start", {29'd0, phase}, 32'd1);
        tick();
        chk("early_done_ignored", {29'd0, phase}, 32'd1);
        tick(); hist_done = 1'b0;
        chk("late_done_accepted", {29'd0, phase}, 32'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_cdf", {29'd0, phase}, 32'd0);

        // Timeout in CDF; a start while busy is ignored.
        start = 1'b1; tick(); start = 1'b1; tick(); start = 1'b0; hist_done = 1'b1;
        tick(); hist_done = 1'b0;
        chk("tmo_cdf_entry", {29'd0, phase}, 32'd2);
        tick(15);
        chk("tmo_cdf_last", {29'd0, phase}, 32'd2);
        tick();
        chk("tmo_err_phase", {29'd0, phase}, 32'd5);
        chk("tmo_err_flag", {31'd0, error}, 32'd1);
        tick();
        chk("tmo_idle_sticky", {29'd0, phase, error}, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("tmo_error_cleared", {31'd0, error}, 32'd0);

        // Abort beats a simultaneous map_done.
        tick(); hist_done = 1'b1; tick(); hist_done = 1'b0;
        tick(); cdf_done = 1'b1; cdf_min_in = 20'h0ABCD; tick(); cdf_done = 1'b0;
        tick(); map_done = 1'b1; abort = 1'b1; n_dn = 0;
        tick(); map_done = 1'b0; abort = 1'b0;
        chk("abort_phase", {29'd0, phase}, 32'd0);
        chk("abort_cycle_count", cycle_count, 32'd6);
        chk("abort_cdf_min", {12'd0, cdf_min}, 32'h0ABCD);
        tick(2);
        chk("abort_count_held", cycle_count, 32'd6);
        chk("abort_no_done", 32'(n_dn), 32'd0);

        // Reset in the middle of CDF, then a normal short run.
        start = 1'b1; tick(); start = 1'b0; tick(); hist_done = 1'b1; tick(); hist_done = 1'b0;
        tick();
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_phase", {29'd0, phase}, 32'd0);
        chk("midrst_cdf_min", {12'd0, cdf_min}, 32'd0);
        chk("midrst_sp_addr", {16'd0, sp_addr}, 32'd0);
        tick(2); reset_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick(); hist_done = 1'b1; tick(); hist_done = 1'b0;
        cdf_min_in = 20'h00042; cdf_done = 1'b1; tick(2); cdf_done = 1'b0;
        map_done = 1'b1; tick(2); map_done = 1'b0;
        chk("rerun_done", {31'd0, done}, 32'd1);
        tick();
        chk("rerun_cycle_count", cycle_count, 32'd7);
        chk("rerun_cdf_min", {12'd0, cdf_min}, 32'h00042);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
